// File: rtl/e_mdu_seq.sv
// ---------------------------------------------------------------------------
// e_mdu_seq : multi-cycle multiply/divide unit for the E stage.
//
// Executes signed/unsigned multiply and divide over a fixed per-class latency
// and holds the results in the architectural HI/LO registers. mthi/mtlo write
// HI/LO directly in a single cycle.
//
// Optional feature macro: MDU_MADD_EN
//   defined   -> ops 7..10 (madd/maddu/msub/msubu) accumulate into {HI,LO}
//   undefined -> ops 7..10 decode as "none"
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   issue mdu_op this cycle
//   mdu_op   in   [3:0] operation code
//   in1      in   [WIDTH-1:0] rs operand (dividend / multiplicand / mthi-mtlo)
//   in2      in   [WIDTH-1:0] rt operand (divisor / multiplier)
//   hi, lo   out  [WIDTH-1:0] HI / LO registers
//   busy     out  registered, operation in flight
//   stall    out  combinational, busy or a multi-cycle op being issued
// ---------------------------------------------------------------------------
module e_mdu_seq #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d;

  logic             is_long_s, is_div_s;
  logic             signed_op_s, div_zero_s, div_ovf_s;
  logic [2*WIDTH-1:0] ext_a_s, ext_b_s, prod_s;
  logic [WIDTH-1:0] b_safe_s, quot_s, rem_s;
  logic [WIDTH-1:0] res_hi_s, res_lo_s;

  // Decode the incoming op into multi-cycle class and divide class.
  always_comb begin
    is_long_s = 1'b0;
    is_div_s  = 1'b0;
    case (mdu_op)
      OP_MULT, OP_MULTU: is_long_s = 1'b1;
      OP_DIV, OP_DIVU: begin
        is_long_s = 1'b1;
        is_div_s  = 1'b1;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_long_s = 1'b1;
`endif
      default: is_long_s = 1'b0;
    endcase
  end

  // State, counter, operand and HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: a multi-cycle issue enters RUN, the last count returns.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && is_long_s) state_d = S_RUN;
        else                    state_d = S_IDLE;
      end
      S_RUN: begin
        if (cnt_q == CNT_ONE) state_d = S_IDLE;
        else                  state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: stall covers the issue cycle before busy registers.
  always_comb begin
    busy_d = (state_d == S_RUN);
    stall  = busy_q | (start & is_long_s);
  end

  // Result computed once from the captured operands; HI/LO read at commit so
  // accumulate ops see the architectural values of that moment.
  always_comb begin
    case (op_q)
      OP_MULT, OP_DIV, OP_MADD, OP_MSUB: signed_op_s = 1'b1;
      default:                           signed_op_s = 1'b0;
    endcase
    ext_a_s = signed_op_s ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b_s = signed_op_s ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod_s  = ext_a_s * ext_b_s;

    div_zero_s = (b_q == '0);
    div_ovf_s  = signed_op_s && (a_q == MOST_NEG) && (b_q == ALL_ONES);
    // Dividing by 1 in the overflow case yields exactly most-negative rem 0.
    b_safe_s   = (div_zero_s || div_ovf_s) ? ONE_W : b_q;
    if (signed_op_s) begin
      quot_s = $signed(a_q) / $signed(b_safe_s);
      rem_s  = $signed(a_q) % $signed(b_safe_s);
    end else begin
      quot_s = a_q / b_safe_s;
      rem_s  = a_q % b_safe_s;
    end

    res_hi_s = hi_q;
    res_lo_s = lo_q;
    case (op_q)
      OP_MULT, OP_MULTU: {res_hi_s, res_lo_s} = prod_s;
      OP_DIV, OP_DIVU: begin
        if (div_zero_s) begin
          res_hi_s = a_q;
          res_lo_s = ALL_ONES;
        end else begin
          res_hi_s = rem_s;
          res_lo_s = quot_s;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: {res_hi_s, res_lo_s} = {hi_q, lo_q} + prod_s;
      OP_MSUB, OP_MSUBU: {res_hi_s, res_lo_s} = {hi_q, lo_q} - prod_s;
`endif
      default: begin
        res_hi_s = hi_q;
        res_lo_s = lo_q;
      end
    endcase
  end

  // Datapath: capture at issue, direct HI/LO writes in IDLE, commit at count end.
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && is_long_s) begin
          cnt_d = is_div_s ? DIV_LOAD : MULT_LOAD;
          op_d  = mdu_op;
          a_d   = in1;
          b_d   = in2;
        end else if (start && (mdu_op == OP_MTHI)) begin
          hi_d = in1;
        end else if (start && (mdu_op == OP_MTLO)) begin
          lo_d = in1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          hi_d = res_hi_s;
          lo_d = res_lo_s;
        end else begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;

endmodule
